// File: rtl/xaui_rx_checker_pkg.sv
// Shared XGMII character codes, word classes, FSM state codes and error codes
// for the XAUI receive traffic checker.
package xaui_rx_checker_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_FAULT = 8'h9C;
  localparam logic [7:0] XGMII_PRE   = 8'h55;
  localparam logic [7:0] XGMII_SFD   = 8'hD5;

  // BADPRE is a lane-0 start whose preamble was rejected; MISALIGN is a
  // start/terminate control character outside lane 0.
  typedef enum logic [2:0] {
    CLS_IDLE,
    CLS_START,
    CLS_TERM,
    CLS_FAULT,
    CLS_DATA,
    CLS_BADCTL,
    CLS_MISALIGN,
    CLS_BADPRE
  } word_class_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEED = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_DATA  = 3'd1;
  localparam logic [2:0] ERR_CTL   = 3'd2;
  localparam logic [2:0] ERR_EARLY = 3'd3;
  localparam logic [2:0] ERR_LEN   = 3'd4;
  localparam logic [2:0] ERR_ALIGN = 3'd5;

endpackage

// File: rtl/xgmii_word_class.sv
// Combinational classifier mapping one 64-bit XGMII word to its word class.
// Honours XAUI_RX_CHECKER_PREAMBLE_EN (start must carry 55..55 D5 preamble).
module xgmii_word_class
  import xaui_rx_checker_pkg::*;
(
  input  logic [63:0]  rxd,
  input  logic [7:0]   rxc,
  output word_class_t  cls
);

  logic misalign;
  logic pre_ok;

  always_comb begin
    misalign = 1'b0;
    for (int i = 1; i < 8; i++) begin
      if (rxc[i] && (rxd[8*i +: 8] == XGMII_START || rxd[8*i +: 8] == XGMII_TERM))
        misalign = 1'b1;
    end
  end

`ifdef XAUI_RX_CHECKER_PREAMBLE_EN
  assign pre_ok = (rxd[63:8] == {XGMII_SFD, {6{XGMII_PRE}}});
`else
  assign pre_ok = 1'b1;
`endif

  always_comb begin
    cls = CLS_BADCTL;
    if (rxc == 8'h00)
      cls = CLS_DATA;
    else if (rxc == 8'hFF && rxd == {8{XGMII_IDLE}})
      cls = CLS_IDLE;
    else if (rxc == 8'hFF && rxd == {{7{XGMII_IDLE}}, XGMII_TERM})
      cls = CLS_TERM;
    else if (rxc == 8'h01 && rxd[7:0] == XGMII_START)
      cls = pre_ok ? CLS_START : CLS_BADPRE;
    else if (rxc == 8'h01 && rxd[7:0] == XGMII_FAULT)
      cls = CLS_FAULT;
    else if (misalign)
      cls = CLS_MISALIGN;
  end

endmodule

// File: rtl/xaui_rx_checker.sv
// XGMII receive checker: verifies incrementing 64-bit payload frames and keeps
// saturating packet/error/fault counters. Optional macro: XAUI_RX_CHECKER_PREAMBLE_EN.
module xaui_rx_checker
  import xaui_rx_checker_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int MAX_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          xgmii_rxd,
  input  logic [7:0]           xgmii_rxc,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] fault_count,
  output logic [2:0]           last_err,
  output logic                 in_frame,
  output logic                 link_ok
);

  localparam int WC_W = $clog2(MAX_WORDS + 2);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    return (inc && v != '1) ? v + 1'b1 : v;
  endfunction

  logic [63:0]     rxd_p1;
  logic [7:0]      rxc_p1;
  logic            vld_p1;
  word_class_t     cls_p1;

  logic [1:0]      state, state_n;
  logic [63:0]     expected, exp_n;
  logic [WC_W-1:0] word_cnt, wc_n;
  logic            frame_err, ferr_n;
  logic            inc_pkt, inc_err, inc_fault;
  logic [2:0]      err_code;
  logic [7:0]      link_cnt;

  // Stage 1: register the raw XGMII word
  always_ff @(posedge clk) begin
    rxd_p1 <= xgmii_rxd;
    rxc_p1 <= xgmii_rxc;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= 1'b1;
  end

  // Stage 2: classify, compare and decide counter updates
  xgmii_word_class u_class (
    .rxd (rxd_p1),
    .rxc (rxc_p1),
    .cls (cls_p1)
  );

  always_comb begin
    state_n   = state;
    exp_n     = expected;
    wc_n      = word_cnt;
    ferr_n    = frame_err;
    inc_pkt   = 1'b0;
    inc_err   = 1'b0;
    inc_fault = 1'b0;
    err_code  = ERR_NONE;
    if (vld_p1) begin
      inc_fault = (cls_p1 == CLS_FAULT);
      case (state)
        ST_IDLE: begin
          if (cls_p1 == CLS_START) begin
            state_n = ST_SEED;
          end else if (cls_p1 == CLS_BADPRE) begin
            inc_err  = 1'b1;
            err_code = ERR_CTL;
          end
        end
        ST_SEED: begin
          case (cls_p1)
            CLS_DATA: begin
              exp_n   = rxd_p1 + 64'd1;
              wc_n    = WC_W'(1);
              ferr_n  = 1'b0;
              state_n = ST_DATA;
            end
            CLS_TERM: begin
              inc_pkt = 1'b1;
              state_n = ST_IDLE;
            end
            default: begin
              inc_err  = 1'b1;
              err_code = (cls_p1 == CLS_MISALIGN) ? ERR_ALIGN : ERR_CTL;
              state_n  = ST_IDLE;
            end
          endcase
        end
        default: begin
          case (cls_p1)
            CLS_DATA: begin
              if (word_cnt == WC_W'(MAX_WORDS)) begin
                inc_err  = 1'b1;
                err_code = ERR_LEN;
                state_n  = ST_IDLE;
              end else begin
                wc_n = word_cnt + 1'b1;
                if (rxd_p1 != expected) begin
                  // Resync on the received value so one bad word is one error
                  exp_n  = rxd_p1 + 64'd1;
                  ferr_n = 1'b1;
                  if (!frame_err) begin
                    inc_err  = 1'b1;
                    err_code = ERR_DATA;
                  end
                end else begin
                  exp_n = expected + 64'd1;
                end
              end
            end
            CLS_TERM: begin
              inc_pkt = ~frame_err;
              state_n = ST_IDLE;
            end
            CLS_START: begin
              inc_err  = 1'b1;
              err_code = ERR_EARLY;
              state_n  = ST_SEED;
            end
            default: begin
              inc_err  = 1'b1;
              err_code = (cls_p1 == CLS_MISALIGN) ? ERR_ALIGN : ERR_CTL;
              state_n  = ST_IDLE;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      frame_err <= ferr_n;
    end
  end

  always_ff @(posedge clk) begin
    expected <= exp_n;
    word_cnt <= wc_n;
  end

  // Counters and sticky error code; clear overrides any same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pkt_count   <= '0;
      err_count   <= '0;
      fault_count <= '0;
      last_err    <= ERR_NONE;
    end else begin
      pkt_count   <= sat_inc(pkt_count, inc_pkt);
      err_count   <= sat_inc(err_count, inc_err);
      fault_count <= sat_inc(fault_count, inc_fault);
      if (inc_err) last_err <= err_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || inc_fault) link_cnt <= 8'd255;
    else if (link_cnt != 8'd0) link_cnt <= link_cnt - 8'd1;
  end

  assign link_ok  = (link_cnt == 8'd0);
  assign in_frame = (state == ST_DATA);

endmodule

// File: tb/tb_xaui_rx_checker.sv
// Scoreboard bench for xaui_rx_checker: directed XGMII vectors, expected
// counter snapshots queued by the stimulus and checked by a separate monitor.
`timescale 1ns/1ps
module tb_xaui_rx_checker;

  localparam int CW = 4;
  localparam int MW = 16;
  localparam logic [63:0] W_IDLE  = 64'h0707_0707_0707_0707;
  localparam logic [63:0] W_TERM  = 64'h0707_0707_0707_07FD;
  localparam logic [63:0] W_START = 64'hD555_5555_5555_55FB;
  localparam logic [63:0] W_FAULT = 64'h0000_0001_0000_009C;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [63:0]   rxd = W_IDLE;
  logic [7:0]    rxc = 8'hFF;
  logic [CW-1:0] pkt_count, err_count, fault_count;
  logic [2:0]    last_err;
  logic          in_frame, link_ok;

  xaui_rx_checker #(.CNT_WIDTH(CW), .MAX_WORDS(MW)) dut (
    .clk         (clk),
    .reset       (reset),
    .xgmii_rxd   (rxd),
    .xgmii_rxc   (rxc),
    .clear       (clear),
    .pkt_count   (pkt_count),
    .err_count   (err_count),
    .fault_count (fault_count),
    .last_err    (last_err),
    .in_frame    (in_frame),
    .link_ok     (link_ok)
  );

  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  typedef struct {
    int    target;
    string name;
    int    pkt, err, flt, le;
    int    inf, lok;
    bit    use_cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   fails  = 0;
  int   last_cyc = 0;

  task automatic chk(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s.%s: got %0d, expected %0d (cycle %0d)", nm, fld, act, req, ncyc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].target <= ncyc) begin
      cur = sb.pop_front();
      if (cur.use_cnt) begin
        chk(cur.name, "pkt_count",   int'(pkt_count),   cur.pkt);
        chk(cur.name, "err_count",   int'(err_count),   cur.err);
        chk(cur.name, "fault_count", int'(fault_count), cur.flt);
        chk(cur.name, "last_err",    int'(last_err),    cur.le);
        chk(cur.name, "in_frame",    int'(in_frame),    cur.inf);
      end else begin
        chk(cur.name, "link_ok", int'(link_ok), cur.lok);
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [7:0] c, input logic clr = 1'b0);
    @(negedge clk);
    rxd = d;
    rxc = c;
    clear = clr;
    last_cyc = ncyc;
  endtask

  task automatic start_w();          send(W_START, 8'h01); endtask
  task automatic term_w();           send(W_TERM, 8'hFF);  endtask
  task automatic idle_w();           send(W_IDLE, 8'hFF);  endtask
  task automatic fault_w();          send(W_FAULT, 8'h01); endtask
  task automatic data_w(input logic [63:0] v); send(v, 8'h00); endtask

  task automatic expect_cnt(input string nm, input int p, input int e, input int f,
                            input int l, input int inf);
    exp_t x;
    x.target = last_cyc + 2; x.name = nm; x.pkt = p; x.err = e; x.flt = f;
    x.le = l; x.inf = inf; x.lok = 0; x.use_cnt = 1'b1;
    sb.push_back(x);
  endtask

  task automatic expect_lok(input string nm, input int lok, input int off);
    exp_t x;
    x.target = last_cyc + off; x.name = nm; x.pkt = 0; x.err = 0; x.flt = 0;
    x.le = 0; x.inf = 0; x.lok = lok; x.use_cnt = 1'b0;
    sb.push_back(x);
  endtask

  task automatic do_clear();
    idle_w();
    idle_w();
    send(W_IDLE, 8'hFF, 1'b1);
    idle_w();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) idle_w();
    reset = 1'b0;
    idle_w();
    sb.push_back('{last_cyc + 1, "reset", 0, 0, 0, 0, 0, 0, 1'b1});
    expect_lok("reset_link", 0, 1);

    // Clean 16-word frame (exactly MAX_WORDS)
    start_w();
    for (int i = 0; i < 16; i++) data_w(64'(i));
    expect_cnt("t1_mid", 0, 0, 0, 0, 1);
    term_w();
    expect_cnt("t1_good", 1, 0, 0, 0, 0);

    // Two corrupted words, counted once, then a clean frame back-to-back
    start_w();
    for (int i = 0; i < 16; i++)
      data_w(i == 5 ? 64'hDEAD : (i == 9 ? 64'h1234 : 64'(i)));
    term_w();
    expect_cnt("t2_err", 1, 1, 0, 1, 0);
    start_w();
    for (int i = 0; i < 8; i++) data_w(64'(i));
    term_w();
    expect_cnt("t2_clean", 2, 1, 0, 1, 0);

    do_clear();
    expect_cnt("clear1", 0, 0, 0, 0, 0);

    // 64-bit wrap
    start_w();
    data_w(64'hFFFF_FFFF_FFFF_FFFE);
    data_w(64'hFFFF_FFFF_FFFF_FFFF);
    data_w(64'h0);
    data_w(64'h1);
    term_w();
    expect_cnt("wrap", 1, 0, 0, 0, 0);

    // Early start, then idle mid-frame
    do_clear();
    start_w();
    for (int i = 0; i < 3; i++) data_w(64'(i));
    start_w();
    expect_cnt("early", 0, 1, 0, 3, 0);
    for (int i = 10; i < 13; i++) data_w(64'(i));
    term_w();
    expect_cnt("early_term", 1, 1, 0, 3, 0);
    start_w();
    data_w(64'h0);
    data_w(64'h1);
    idle_w();
    expect_cnt("idle_mid", 1, 2, 0, 2, 0);

    // Terminate in lane 4
    do_clear();
    start_w();
    data_w(64'h0);
    data_w(64'h1);
    send(64'h0707_07FD_0000_0002, 8'hF0);
    expect_cnt("misalign", 0, 1, 0, 5, 0);
    term_w();
    expect_cnt("misalign_term", 0, 1, 0, 5, 0);

    // MAX_WORDS + 1 data words
    do_clear();
    start_w();
    for (int i = 0; i < 17; i++) data_w(64'(i));
    expect_cnt("length", 0, 1, 0, 4, 0);
    term_w();
    expect_cnt("len_term", 0, 1, 0, 4, 0);

    // Fault inside a frame, then clear colliding with a fault increment
    do_clear();
    start_w();
    data_w(64'h0);
    fault_w();
    expect_cnt("fault_data", 0, 1, 1, 2, 0);
    fault_w();
    send(W_IDLE, 8'hFF, 1'b1);
    expect_cnt("clear_wins", 0, 0, 0, 0, 0);

    // link_ok hold-off after a single fault word
    do_clear();
    fault_w();
    expect_cnt("fault_cnt", 0, 0, 1, 0, 0);
    expect_lok("link_after_fault", 0, 2);
    expect_lok("link_hold", 0, 256);
    expect_lok("link_recover", 1, 258);
    repeat (262) idle_w();

    // Reset mid-frame discards the frame
    start_w();
    data_w(64'h0);
    data_w(64'h1);
    reset = 1'b1;
    idle_w();
    idle_w();
    reset = 1'b0;
    term_w();
    expect_cnt("reset_mid", 0, 0, 0, 0, 0);
    expect_lok("reset_mid_link", 0, 2);

    // Saturation of all three counters, then clear
    repeat (20) fault_w();
    for (int i = 0; i < 17; i++) begin
      start_w();
      term_w();
    end
    for (int i = 0; i < 17; i++) begin
      start_w();
      data_w(64'h0);
      idle_w();
    end
    expect_cnt("saturate", 15, 15, 15, 2, 0);
    do_clear();
    expect_cnt("sat_clear", 0, 0, 0, 0, 0);

    repeat (4) idle_w();
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      chk(cur.name, "unchecked", 0, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
